mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle control unit for the RV32I subset (lw, sw, R-type, I-type ALU, beq, jal).
- Main FSM sequences the shared datapath (PC, instruction register, single ALU, unified memory, register file) over 3–5 cycles per instruction.
- Emits ALUOp to the existing ALU decoder, which produces ALUControl.
- Adds a memory-ready handshake so fetch and data accesses stall on slow memory.

Parameters:
- none; opcodes fixed: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; FSM to Fetch
- op  in  7  instruction opcode field from instruction register
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction and old-PC register enable
- ResultSrc  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 data
- ALUSrcB  out  2  00 rs2 data, 01 ImmExt, 10 constant 4
- ALUOp  out  2  to ALU decoder: 00 add, 01 sub, 10 by funct
- ImmSrc  out  2  immediate format select
- RegWrite  out  1  register file write enable
- illegal  out  1  unrecognised opcode detected in Decode
- state  out  4  current FSM state, for debug

Behaviour:
- State encoding: Fetch 0, Decode 1, MemAdr 2, MemRead 3, MemWB 4, MemWrite 5, ExecuteR 6, ALUWB 7, ExecuteI 8, JAL 9, BEQ 10. Codes 11–15 go to Fetch next cycle with all outputs 0.
- Reset: state = Fetch, asynchronously. While reset is high, every control output is the Fetch value with mem_ready gating applied.
- All outputs not listed for a state are 0.
- Fetch:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCUpdate = mem_ready.
  - Stay in Fetch while mem_ready=0; go to Decode when mem_ready=1.
- Decode: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
  - lw, sw → MemAdr
  - R → ExecuteR
  - I → ExecuteI
  - jal → JAL
  - beq → BEQ
  - any other op → Fetch, with illegal=1 for this cycle only.
- MemAdr: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is MemRead if op=lw, else MemWrite.
- MemRead: AdrSrc=1, ResultSrc=00. Hold until mem_ready=1, then MemWB.
- MemWB: ResultSrc=01, RegWrite=1, then Fetch.
- MemWrite: AdrSrc=1, ResultSrc=00, MemWrite=1 for every cycle in the state. Hold until mem_ready=1, then Fetch.
- ExecuteR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then Fetch.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, then ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, then Fetch.
- PCWrite = PCUpdate | (Branch & Zero). PCUpdate and Branch are internal only.
- ImmSrc is purely combinational from op, independent of state: I-type and lw 00, sw 01, beq 10, jal 11, all others 00.
- Latency with mem_ready tied high:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and I-type: 4 cycles
  - jal: 4 cycles
  - beq: 3 cycles
- Each cycle of mem_ready=0 in Fetch, MemRead or MemWrite adds one cycle.
- op must be stable from Decode until the instruction returns to Fetch. The controller samples op in Decode and MemAdr only.
- Reset asserted mid-instruction: state is Fetch immediately. No RegWrite or MemWrite from the aborted instruction occurs after reset asserts.
- Outputs are combinational from state, plus op, Zero and mem_ready where stated. There is no output registering.

Test Plan:
- Reset mid-ExecuteR, released with mem_ready=1 → state=0; IRWrite=1 and PCWrite=1 on the first clk edge; Decode reached on the next edge.
- op=0000011 (lw), mem_ready=1 → states 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; ImmSrc=00 throughout.
- op=0100011 (sw), mem_ready low for 2 cycles in MemWrite → states 0,1,2,5,5,5,0; MemWrite=1 for all 3 state-5 cycles; RegWrite never 1.
- op=1100011 (beq): Zero=1 → PCWrite=1 in state 10 with ALUOp=01. Repeat with Zero=0 → PCWrite=0. ImmSrc=10 in both cases.
- op=1101111 (jal) → states 0,1,9,7,0; PCWrite=1 in state 9; RegWrite=1 in state 7; ImmSrc=11.
- op=1111111 → illegal=1 for exactly one cycle in state 1; next state is 0; no RegWrite or MemWrite. Also mem_ready=0 for 3 cycles in Fetch → IRWrite and PCWrite stay 0 until mem_ready rises.

Source files
------------

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// The controller is the master: it drives the datapath controls and reads op/Zero/mem_ready.
interface mc_controller_if;
   logic [6:0] op;
   logic       Zero;
   logic       mem_ready;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] ImmSrc;
   logic       RegWrite;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  op, Zero, mem_ready,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUOp, ImmSrc, RegWrite, illegal, state
   );

   modport slave (
      output op, Zero, mem_ready,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUOp, ImmSrc, RegWrite, illegal, state
   );
endinterface

// File: rtl/mc_controller.sv
// Multicycle RV32I control unit (lw, sw, R, I, beq, jal) with a memory-ready stall handshake.
// Outputs are decoded combinationally from the current state; only the state is registered.
module mc_controller (
   input logic           clk,
   input logic           reset,
   mc_controller_if.master bus
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEMADR    = 4'd2,
      MEMREAD   = 4'd3,
      MEMWB     = 4'd4,
      MEMWRITE  = 4'd5,
      EXECUTER  = 4'd6,
      ALUWB     = 4'd7,
      EXECUTEI  = 4'd8,
      JAL       = 4'd9,
      BEQ       = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   state_t state_q;
   logic   pc_update;
   logic   branch;

   // Fetch, MemRead and MemWrite hold until the memory reports completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         case (state_q)
            FETCH:    if (bus.mem_ready) state_q <= DECODE;
            DECODE: begin
               case (bus.op)
                  OP_LW, OP_SW: state_q <= MEMADR;
                  OP_R:         state_q <= EXECUTER;
                  OP_I:         state_q <= EXECUTEI;
                  OP_JAL:       state_q <= JAL;
                  OP_BEQ:       state_q <= BEQ;
                  default:      state_q <= FETCH;
               endcase
            end
            MEMADR:   state_q <= (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (bus.mem_ready) state_q <= MEMWB;
            MEMWB:    state_q <= FETCH;
            MEMWRITE: if (bus.mem_ready) state_q <= FETCH;
            EXECUTER: state_q <= ALUWB;
            EXECUTEI: state_q <= ALUWB;
            ALUWB:    state_q <= FETCH;
            JAL:      state_q <= ALUWB;
            BEQ:      state_q <= FETCH;
            default:  state_q <= FETCH;
         endcase
      end
   end

   always_comb begin
      bus.AdrSrc    = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.IRWrite   = 1'b0;
      bus.ResultSrc = 2'b00;
      bus.ALUSrcA   = 2'b00;
      bus.ALUSrcB   = 2'b00;
      bus.ALUOp     = 2'b00;
      bus.RegWrite  = 1'b0;
      bus.illegal   = 1'b0;
      pc_update     = 1'b0;
      branch        = 1'b0;
      case (state_q)
         FETCH: begin
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            bus.IRWrite   = bus.mem_ready;
            pc_update     = bus.mem_ready;
         end
         DECODE: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b01;
            case (bus.op)
               OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: bus.illegal = 1'b0;
               default:                                  bus.illegal = 1'b1;
            endcase
         end
         MEMADR: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
         end
         MEMREAD: begin
            bus.AdrSrc = 1'b1;
         end
         MEMWB: begin
            bus.ResultSrc = 2'b01;
            bus.RegWrite  = 1'b1;
         end
         MEMWRITE: begin
            bus.AdrSrc   = 1'b1;
            bus.MemWrite = 1'b1;
         end
         EXECUTER: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUOp   = 2'b10;
         end
         EXECUTEI: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
            bus.ALUOp   = 2'b10;
         end
         ALUWB: begin
            bus.RegWrite = 1'b1;
         end
         JAL: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b10;
            pc_update   = 1'b1;
         end
         BEQ: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUOp   = 2'b01;
            branch      = 1'b1;
         end
         default: begin
            bus.illegal = 1'b0;
         end
      endcase
   end

   assign bus.PCWrite = pc_update | (branch & bus.Zero);
   assign bus.state   = state_q;

   // Immediate format depends only on the opcode so the extender can work ahead of Decode.
   always_comb begin
      bus.ImmSrc = 2'b00;
      case (bus.op)
         OP_SW:   bus.ImmSrc = 2'b01;
         OP_BEQ:  bus.ImmSrc = 2'b10;
         OP_JAL:  bus.ImmSrc = 2'b11;
         default: bus.ImmSrc = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: each instruction is expanded into its expected list of states,
// with wait states repeated for every cycle memory is not ready.
module tb_mc_controller;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   mc_controller_if bus();

   mc_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   // Per-state control table indexed by state code 0..10.
   int expSrcA[11]   = '{0, 1, 2, 0, 0, 0, 2, 0, 2, 1, 2};
   int expSrcB[11]   = '{2, 1, 1, 0, 0, 0, 0, 0, 1, 2, 0};
   int expAluOp[11]  = '{0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 1};
   int expResSrc[11] = '{2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

   function automatic bit isLegal(input logic [6:0] o);
      return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
             (o == OP_BEQ) || (o == OP_JAL);
   endfunction

   function automatic int immFor(input logic [6:0] o);
      if (o == OP_SW)  return 1;
      if (o == OP_BEQ) return 2;
      if (o == OP_JAL) return 3;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Compares every controller output against the table for the expected state.
   task automatic checkOutput(input int s, input bit mr, input bit z, input logic [6:0] o);
      chk("state",     32'(bus.state),     32'(s));
      chk("AdrSrc",    32'(bus.AdrSrc),    32'(s == 3 || s == 5));
      chk("MemWrite",  32'(bus.MemWrite),  32'(s == 5));
      chk("IRWrite",   32'(bus.IRWrite),   32'(s == 0 && mr));
      chk("ResultSrc", 32'(bus.ResultSrc), 32'(expResSrc[s]));
      chk("ALUSrcA",   32'(bus.ALUSrcA),   32'(expSrcA[s]));
      chk("ALUSrcB",   32'(bus.ALUSrcB),   32'(expSrcB[s]));
      chk("ALUOp",     32'(bus.ALUOp),     32'(expAluOp[s]));
      chk("RegWrite",  32'(bus.RegWrite),  32'(s == 4 || s == 7));
      chk("PCWrite",   32'(bus.PCWrite),   32'((s == 0 && mr) || s == 9 || (s == 10 && z)));
      chk("illegal",   32'(bus.illegal),   32'(s == 1 && !isLegal(o)));
      chk("ImmSrc",    32'(bus.ImmSrc),    32'(immFor(o)));
   endtask

   // Runs one instruction from Fetch back to Fetch. Entered after a rising edge, before the
   // falling edge. abortAt >= 0 asserts reset once that state has been checked.
   task automatic applyStimulus(input logic [6:0] o, input int fetchStall, input int memStall,
                                input bit randomMr, input bit z, input int abortAt);
      int path[$];
      int idx;
      int fs;
      int ms;
      int budget;
      int s;
      bit mr;
      path.delete();
      path.push_back(0);
      path.push_back(1);
      case (o)
         OP_LW:  begin path.push_back(2); path.push_back(3); path.push_back(4); end
         OP_SW:  begin path.push_back(2); path.push_back(5); end
         OP_R:   begin path.push_back(6); path.push_back(7); end
         OP_I:   begin path.push_back(8); path.push_back(7); end
         OP_JAL: begin path.push_back(9); path.push_back(7); end
         OP_BEQ: path.push_back(10);
         default: ;
      endcase
      idx = 0; fs = 0; ms = 0; budget = 0;
      while (idx < path.size() && budget < 100) begin
         @(negedge clk);
         s = path[idx];
         if (randomMr)                mr = ($urandom_range(0, 3) != 0);
         else if (s == 0)             mr = (fs >= fetchStall);
         else if (s == 3 || s == 5)   mr = (ms >= memStall);
         else                         mr = 1'b1;
         bus.mem_ready = mr;
         bus.Zero      = (o == OP_BEQ) ? z : 1'($urandom_range(0, 1));
         bus.op        = o;
         #1 checkOutput(s, mr, bus.Zero, o);
         if (s == abortAt) begin
            #1 reset = 1'b1;
            bus.mem_ready = 1'b1;
            #1 checkOutput(0, 1'b1, bus.Zero, o);
            @(posedge clk);
            #1 checkOutput(0, 1'b1, bus.Zero, o);
            reset = 1'b0;
            return;
         end
         @(posedge clk);
         if (s == 0 && !mr)                    fs++;
         else if ((s == 3 || s == 5) && !mr)   ms++;
         else                                  idx++;
         budget++;
      end
      chk("instr complete", 32'(idx), 32'(path.size()));
   endtask

   initial begin
      logic [6:0] ops[6];
      logic [6:0] o;
      int pick;
      ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R;
      ops[3] = OP_I;  ops[4] = OP_BEQ; ops[5] = OP_JAL;

      reset = 1'b1;
      bus.op = OP_LW;
      bus.mem_ready = 1'b0;
      bus.Zero = 1'b0;
      #2 checkOutput(0, 1'b0, 1'b0, OP_LW);
      bus.mem_ready = 1'b1;
      #1 checkOutput(0, 1'b1, 1'b0, OP_LW);
      @(posedge clk);
      #1 reset = 1'b0;

      applyStimulus(OP_LW,  0, 0, 1'b0, 1'b0, -1);
      applyStimulus(OP_SW,  0, 2, 1'b0, 1'b0, -1);
      applyStimulus(OP_BEQ, 0, 0, 1'b0, 1'b1, -1);
      applyStimulus(OP_BEQ, 0, 0, 1'b0, 1'b0, -1);
      applyStimulus(OP_JAL, 0, 0, 1'b0, 1'b0, -1);
      applyStimulus(OP_BAD, 3, 0, 1'b0, 1'b0, -1);
      applyStimulus(OP_R,   0, 0, 1'b0, 1'b0, -1);
      applyStimulus(OP_I,   1, 0, 1'b0, 1'b0, -1);
      applyStimulus(OP_LW,  2, 3, 1'b0, 1'b0, -1);
      applyStimulus(OP_R,   0, 0, 1'b0, 1'b0, 6);
      applyStimulus(OP_R,   0, 0, 1'b0, 1'b0, -1);
      applyStimulus(OP_SW,  0, 0, 1'b0, 1'b0, 5);
      applyStimulus(OP_LW,  0, 0, 1'b0, 1'b0, 4);

      // Random instruction mix, including arbitrary (usually illegal) opcodes.
      for (int i = 0; i < 60; i++) begin
         pick = $urandom_range(0, 6);
         if (pick == 6) o = 7'($urandom_range(0, 127));
         else           o = ops[pick];
         applyStimulus(o, 0, 0, 1'b1, 1'($urandom_range(0, 1)), -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
